// File: rtl/bcd_to_bin32.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out, one shift per clock.
// Operands with any digit above 9 are rejected in one cycle with err set.
module bcd_to_bin32 #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned BIN_W  = 32
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned WorkW = BcdW + BIN_W;
  localparam int unsigned CntW  = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WorkW-1:0]  work_q, work_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [WorkW-1:0]  shifted;
  logic [WorkW-1:0]  adjusted;
  logic              bad_digit;

  // One iteration: shift right, then pull every BCD digit >= 8 back down by 3.
  always_comb begin
    shifted  = work_q >> 1;
    adjusted = shifted;
    for (int i = 0; i < DIGITS; i++) begin
      if (shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
        adjusted[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (bad_digit) begin
            bin_d  = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            work_d  = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        work_d = adjusted;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          bin_d   = adjusted[BIN_W-1:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == StShift);
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin32.sv
// Scoreboard bench for bcd_to_bin32: expected results are queued at stimulus time
// and checked against each done pulse, including latency and hold behaviour.
module tb_bcd_to_bin32;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bcd_in = '0;
  logic        busy, done, err;
  logic [31:0] bin_out;

  bcd_to_bin32 #(.DIGITS(8), .BIN_W(32)) dut (
    .CLK     (CLK),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] bin;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          busy_run = 0;
  logic        prev_done = 1'b0;
  logic [31:0] held_bin = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Decimal reference: weights each digit by its power of ten; bad digits force err.
  function automatic logic [32:0] model(input logic [31:0] b);
    logic [31:0] acc;
    logic        bad;
    logic [3:0]  d;
    acc = '0;
    bad = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) bad = 1'b1;
      acc = acc * 10 + 32'(d);
    end
    return bad ? {1'b1, 32'd0} : {1'b0, acc};
  endfunction

  task automatic push(input logic [31:0] v, input int accept_cyc);
    logic [32:0] m;
    exp_t        e;
    m = model(v);
    e.err = m[32];
    e.bin = m[31:0];
    e.exp_cyc = accept_cyc + (m[32] ? 0 : 32);
    sb.push_back(e);
  endtask

  // Returns just after the accepting edge.
  task automatic convert(input logic [31:0] v);
    @(posedge CLK); #1;
    bcd_in = v;
    start  = 1'b1;
    push(v, cyc + 1);
    @(posedge CLK); #1;
    start = 1'b0;
    if (!model(v)[32]) check("busy_after_accept", busy, 1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (2) @(posedge CLK);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
      held_bin  = '0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("bin_out", bin_out, e.bin);
          check("err", err, e.err);
          check("latency", cyc, e.exp_cyc);
          check("busy_at_done", busy, 0);
          held_bin = e.bin;
        end
        check("done_width", prev_done, 0);
      end else begin
        check("bin_held", bin_out, held_bin);
      end
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", busy_run, 32);
        busy_run = 0;
      end
      prev_done = done;
    end
  end

  initial begin
    logic [31:0] v;
    int          a1;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_bin", bin_out, 0);
    rst = 1'b0;

    convert(32'h0000_0000);
    drain(100);
    convert(32'h0000_1234);
    drain(100);
    convert(32'h9999_9999);
    drain(100);
    convert(32'h0000_0001);
    drain(100);

    // Error path, then a valid operand clears err at acceptance.
    convert(32'h0000_001A);
    drain(10);
    convert(32'h0000_0042);
    check("err_clear", err, 0);
    drain(100);

    // Starts during a conversion must be ignored.
    convert(32'h0000_5678);
    repeat (4) @(posedge CLK);
    #1; bcd_in = 32'h1; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (14) @(posedge CLK);
    #1; bcd_in = 32'h1; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    drain(100);

    // start held high: second acceptance lands BIN_W+1 cycles after the first.
    @(posedge CLK); #1;
    bcd_in = 32'h0000_0250;
    start  = 1'b1;
    a1 = cyc + 1;
    push(32'h0000_0250, a1);
    push(32'h0000_9999, a1 + 33);
    @(posedge CLK); #1;
    bcd_in = 32'h0000_9999;
    repeat (39) @(posedge CLK);
    #1; start = 1'b0;
    bcd_in = 32'h0000_0777;
    drain(100);

    // Reset mid-conversion discards the result and suppresses done.
    convert(32'h8765_4321);
    repeat (9) @(posedge CLK);
    #1; rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_bin", bin_out, 0);
    repeat (2) @(posedge CLK);
    #1; rst = 1'b0;
    repeat (40) @(posedge CLK);
    convert(32'h8765_4321);
    drain(100);

    // A few random operands, some carrying non-decimal digits.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) begin
        v[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if (k % 3 == 2) v[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      convert(v);
      drain(100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
